// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-organised memory, with
// read-modify-write for narrow stores. Optional build macro: LSU_ALIGN_CHECK_EN.
module load_store_unit #(
  parameter int READ_LATENCY     = 1,
  parameter int WORD_INDEX_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic                        reqWrite,
  input  logic [1:0]                  reqSize,
  input  logic                        reqSigned,
  input  logic [31:0]                 reqAddress,
  input  logic [31:0]                 reqWriteData,
  output logic                        respValid,
  output logic [31:0]                 respData,
  output logic                        respError,
  output logic [WORD_INDEX_WIDTH-1:0] memAddress,
  output logic [31:0]                 memWriteData,
  output logic                        memRead,
  output logic                        memWrite,
  input  logic [31:0]                 memReadData
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  logic [2:0]  state;
  logic [1:0]  wait_cnt;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] resp_data_q;
  logic        resp_error_q;
  logic        misaligned;
  logic        req_error;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((reqSize == SIZE_HALF) && reqAddress[0]) ||
                      ((reqSize == SIZE_WORD) && (reqAddress[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_error = (reqSize == SIZE_BAD) || misaligned;

  // Strobes are pure state decodes, so each is high for exactly one state-cycle.
  assign reqReady  = (state == IDLE);
  assign memRead   = (state == READ);
  assign memWrite  = (state == WRITE);
  assign respValid = (state == RESP);
  assign respData  = resp_data_q;
  assign respError = resp_error_q;

  // NOTE: every path through a function assigns the result first, so no
  // stale value (and no latch when used from combinational code) is possible.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic        sgn,
                                          input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [15:0] half;
    extract = word;
    shifted = word >> {lane, 3'b000};
    half    = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: extract = {{16{sgn & half[15]}}, half};
      default:   extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [1:0]  size,
                                        input logic [1:0]  lane,
                                        input logic [15:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    mask = 32'h0;
    ins  = 32'h0;
    case (size)
      SIZE_BYTE: begin
        mask = 32'h0000_00ff << {lane, 3'b000};
        ins  = {24'h0, data[7:0]} << {lane, 3'b000};
      end
      SIZE_HALF: begin
        mask = 32'h0000_ffff << {lane[1], 4'b0000};
        ins  = {16'h0, data} << {lane[1], 4'b0000};
      end
      default: ;
    endcase
    merge = (word & ~mask) | (ins & mask);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      resp_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
      memAddress   <= '0;
      memWriteData <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            write_q    <= reqWrite;
            size_q     <= reqSize;
            signed_q   <= reqSigned;
            lane_q     <= reqAddress[1:0];
            wdata_q    <= reqWriteData[15:0];
            memAddress <= WORD_INDEX_WIDTH'(reqAddress >> 2);
            if (req_error) begin
              resp_error_q <= 1'b1;
              state        <= RESP;
            end else if (reqWrite && (reqSize == SIZE_WORD)) begin
              memWriteData <= reqWriteData;
              state        <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (write_q) begin
              memWriteData <= merge(memReadData, size_q, lane_q, wdata_q);
              state        <= WRITE;
            end else begin
              resp_data_q <= extract(memReadData, size_q, signed_q, lane_q);
              state       <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WRITE: state <= RESP;
        RESP: begin
          resp_data_q  <= 32'h0;
          resp_error_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at READ_LATENCY=1 (a_*) and
// one at READ_LATENCY=3 (b_*), each backed by a small latency-accurate memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        resetN;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        a_req_valid, b_req_valid;

  logic        a_ready, a_resp_valid, a_resp_error, a_mem_read, a_mem_write;
  logic [31:0] a_resp_data, a_mem_address, a_mem_write_data, a_mem_read_data;
  logic        b_ready, b_resp_valid, b_resp_error, b_mem_read, b_mem_write;
  logic [31:0] b_resp_data, b_mem_address, b_mem_write_data, b_mem_read_data;

  always #5 clock = ~clock;

  load_store_unit #(.READ_LATENCY(1), .WORD_INDEX_WIDTH(32)) dut_a (
    .clock(clock), .resetN(resetN),
    .reqValid(a_req_valid), .reqReady(a_ready), .reqWrite(req_write),
    .reqSize(req_size), .reqSigned(req_signed), .reqAddress(req_address),
    .reqWriteData(req_write_data),
    .respValid(a_resp_valid), .respData(a_resp_data), .respError(a_resp_error),
    .memAddress(a_mem_address), .memWriteData(a_mem_write_data),
    .memRead(a_mem_read), .memWrite(a_mem_write), .memReadData(a_mem_read_data)
  );

  load_store_unit #(.READ_LATENCY(3), .WORD_INDEX_WIDTH(32)) dut_b (
    .clock(clock), .resetN(resetN),
    .reqValid(b_req_valid), .reqReady(b_ready), .reqWrite(req_write),
    .reqSize(req_size), .reqSigned(req_signed), .reqAddress(req_address),
    .reqWriteData(req_write_data),
    .respValid(b_resp_valid), .respData(b_resp_data), .respError(b_resp_error),
    .memAddress(b_mem_address), .memWriteData(b_mem_write_data),
    .memRead(b_mem_read), .memWrite(b_mem_write), .memReadData(b_mem_read_data)
  );

  // Memory models: data appears exactly READ_LATENCY cycles after the strobe
  // cycle and is junk otherwise, so a mistimed sample is visible.
  logic        pre_we = 1'b0;
  logic        pre_sel = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'h0;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clock) begin
    pipe_a    <= a_mem_read ? mem_a[a_mem_address[3:0]] : 32'hBAD0_BAD0;
    pipe_b[0] <= b_mem_read ? mem_b[b_mem_address[3:0]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (pre_we && !pre_sel) mem_a[pre_idx] <= pre_data;
    else if (a_mem_write)   mem_a[a_mem_address[3:0]] <= a_mem_write_data;
    if (pre_we && pre_sel)  mem_b[pre_idx] <= pre_data;
    else if (b_mem_write)   mem_b[b_mem_address[3:0]] <= b_mem_write_data;
  end
  assign a_mem_read_data = pipe_a;
  assign b_mem_read_data = pipe_b[2];

  logic sel = 1'b0;
  wire        c_ready      = sel ? b_ready      : a_ready;
  wire        c_read       = sel ? b_mem_read   : a_mem_read;
  wire        c_write      = sel ? b_mem_write  : a_mem_write;
  wire        c_resp_valid = sel ? b_resp_valid : a_resp_valid;
  wire        c_resp_err   = sel ? b_resp_error : a_resp_error;
  wire [31:0] c_resp_data  = sel ? b_resp_data  : a_resp_data;
  wire [31:0] c_addr       = sel ? b_mem_address    : a_mem_address;
  wire [31:0] c_wdata      = sel ? b_mem_write_data : a_mem_write_data;

  int n_cmp = 0;
  int n_err = 0;
  int t_rd, t_wr, t_resp, n_rd, n_wr, n_resp, bad;
  logic [31:0] rd_addr, wr_addr, wr_data, resp_data;
  logic        resp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic s, input logic [3:0] idx, input logic [31:0] data);
    @(negedge clock);
    pre_we = 1'b1; pre_sel = s; pre_idx = idx; pre_data = data;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic s, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clock);
    sel = s;
    check("ready_before_accept", {31'b0, c_ready}, 32'd1);
    req_write = wr; req_size = sz; req_signed = sgn;
    req_address = addr; req_write_data = wd;
    if (s) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    @(posedge clock);
    #1 a_req_valid = 1'b0; b_req_valid = 1'b0;
  endtask

  task automatic observe(input int cycles);
    t_rd = -1; t_wr = -1; t_resp = -1; n_rd = 0; n_wr = 0; n_resp = 0; bad = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; resp_data = '0; resp_err = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clock);
      if (c_read) begin n_rd++; if (t_rd < 0) t_rd = k; rd_addr = c_addr; end
      if (c_write) begin
        n_wr++; if (t_wr < 0) t_wr = k; wr_addr = c_addr; wr_data = c_wdata;
      end
      if (c_resp_valid) begin
        n_resp++; if (t_resp < 0) t_resp = k; resp_data = c_resp_data; resp_err = c_resp_err;
      end else if (c_resp_data != 32'h0 || c_resp_err) bad++;
      if (c_read && c_write) bad++;
    end
  endtask

  // t_* of -1 means "no such strobe expected".
  task automatic expect_txn(input string tag, input int e_rd, input int e_wr,
                            input int e_resp, input logic [31:0] e_data, input logic e_err);
    check({tag, ".t_read"}, t_rd, e_rd);
    check({tag, ".n_read"}, n_rd, (e_rd > 0) ? 1 : 0);
    check({tag, ".t_write"}, t_wr, e_wr);
    check({tag, ".n_write"}, n_wr, (e_wr > 0) ? 1 : 0);
    check({tag, ".t_resp"}, t_resp, e_resp);
    check({tag, ".n_resp"}, n_resp, 1);
    check({tag, ".resp_data"}, resp_data, e_data);
    check({tag, ".resp_error"}, {31'b0, resp_err}, {31'b0, e_err});
    check({tag, ".protocol"}, bad, 0);
  endtask

  initial begin
    resetN = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = '0; req_write_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.a_ready", {31'b0, a_ready}, 32'd1);
    check("rst.a_strobes", {29'b0, a_mem_read, a_mem_write, a_resp_valid}, 32'd0);
    check("rst.a_addr", a_mem_address, 32'h0);
    check("rst.b_ready", {31'b0, b_ready}, 32'd1);
    check("rst.b_data", b_resp_data | b_mem_write_data, 32'h0);
    resetN = 1'b1;

    preload(1'b0, 4'd5, 32'h8899_AABB);
    preload(1'b0, 4'd3, 32'h1122_3344);
    preload(1'b0, 4'd1, 32'hCAFE_0001);
    preload(1'b1, 4'd2, 32'h0000_0000);

    // READ_LATENCY=1 loads from word 5
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h15, 32'h0); observe(8);
    expect_txn("lb_signed", 1, -1, 3, 32'hFFFF_FFAA, 1'b0);
    check("lb_signed.addr", rd_addr, 32'd5);
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0); observe(8);
    expect_txn("lh_unsigned", 1, -1, 3, 32'h0000_8899, 1'b0);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0); observe(8);
    expect_txn("lw", 1, -1, 3, 32'h8899_AABB, 1'b0);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h17, 32'h0); observe(8);
    expect_txn("lb_unsigned_top", 1, -1, 3, 32'h0000_0088, 1'b0);
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h14, 32'h0); observe(8);
    expect_txn("lh_signed_low", 1, -1, 3, 32'hFFFF_AABB, 1'b0);
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFD5, 32'h0); observe(8);
    expect_txn("lb_high_addr", 1, -1, 3, 32'hFFFF_FFAA, 1'b0);
    check("lb_high_addr.addr", rd_addr, 32'h3FFF_FFF5);

    // Narrow stores: read-modify-write on word 3
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00EE); observe(8);
    expect_txn("sb", 1, 3, 4, 32'h0, 1'b0);
    check("sb.wdata", wr_data, 32'h1122_EE44);
    check("sb.waddr", wr_addr, 32'd3);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'hABCD_1234); observe(8);
    expect_txn("sh", 1, 3, 4, 32'h0, 1'b0);
    check("sh.wdata", wr_data, 32'h1234_EE44);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0); observe(8);
    expect_txn("lw_after_sh", 1, -1, 3, 32'h1234_EE44, 1'b0);

    // Misaligned word load and illegal size
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0); observe(8);
`ifdef LSU_ALIGN_CHECK_EN
    expect_txn("lw_misaligned", -1, -1, 1, 32'h0, 1'b1);
`else
    expect_txn("lw_misaligned", 1, -1, 3, 32'hCAFE_0001, 1'b0);
`endif
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h0D, 32'h5A5A_5A5A); observe(8);
    expect_txn("size_illegal", -1, -1, 1, 32'h0, 1'b1);

    // READ_LATENCY=3
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF); observe(10);
    expect_txn("b_sw", -1, 1, 2, 32'h0, 1'b0);
    check("b_sw.waddr", wr_addr, 32'd2);
    check("b_sw.wdata", wr_data, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0); observe(10);
    expect_txn("b_lb", 1, -1, 5, 32'hFFFF_FFDE, 1'b0);

    // Reset during WAIT of a half store
    issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_5555);
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    check("midrst.ready", {31'b0, c_ready}, 32'd1);
    check("midrst.strobes", {29'b0, c_read, c_write, c_resp_valid}, 32'd0);
    check("midrst.addr", c_addr, 32'h0);
    check("midrst.wdata", c_wdata, 32'h0);
    check("midrst.resp", {c_resp_data[30:0], c_resp_err}, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    observe(12);
    check("midrst.no_write", n_wr, 0);
    check("midrst.no_resp", n_resp, 0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0); observe(10);
    expect_txn("midrst.lw", 1, -1, 5, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_5555); observe(10);
    expect_txn("post_rst_sh", 1, 5, 6, 32'h0, 1'b0);
    check("post_rst_sh.wdata", wr_data, 32'h5555_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
